// File: rtl/dma_mstr.sv
// Single-channel byte DMA master: moves dma_len bytes between the memory bus and the tx/rx card streams.
// Optional bus watchdog enabled by defining DMA_MSTR_BUS_TIMEOUT_EN (drives dma_err).
module dma_mstr #(
  parameter int FIFO_DEPTH = 8,
  parameter int TMO_CYC    = 255
) (
  input  logic        bus_clk,
  input  logic        rstn,
  input  logic        dma_start,
  input  logic        dma_dir,
  input  logic [16:0] dma_saddr,
  input  logic [15:0] dma_len,
  input  logic        dma_abort,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_err,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [16:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic        bus_ready,
  input  logic        bus_rdata_ready,
  input  logic [7:0]  bus_rdata
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 ||
      TMO_CYC < 1 || TMO_CYC > 255) begin : g_param_chk
    $error("dma_mstr: FIFO_DEPTH must be a power of 2 in 2..64, TMO_CYC in 1..255");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GAP, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  logic        r_dir, r_abort, r_rd, r_wr;
  logic [16:0] r_addr;
  logic [15:0] r_len, r_rem, r_rx_cnt;
  logic [7:0]  r_wdata;
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;

  logic        w_empty, w_full, w_cmpl_rd, w_cmpl_wr, w_cmpl, w_issue;
  logic        w_push, w_pop, w_rx_push, w_tx_pop, w_flush, w_tmo;
  logic [7:0]  w_push_data;
  logic [15:0] w_rem_nxt;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == FULL_CNT);
  assign w_cmpl_rd = (r_state == S_WAIT) && !r_dir && bus_rdata_ready;
  assign w_cmpl_wr = (r_state == S_WAIT) &&  r_dir && bus_ready;
  assign w_cmpl    = w_cmpl_rd | w_cmpl_wr;
  assign w_issue   = (r_state == S_ISSUE) && !dma_abort && bus_ready && (r_dir ? !w_empty : !w_full);
  assign w_rem_nxt = r_rem - 16'd1;

  assign dma_busy  = (r_state != S_IDLE);
  assign dma_done  = (r_state == S_DONE);
  assign tx_valid  = !r_dir && !w_empty;
  assign tx_data   = r_mem[r_rptr];
  // The rx side stops at exactly len accepted bytes so nothing past the transfer is swallowed.
  assign rx_ready  = r_dir && (r_state != S_IDLE) && (r_state != S_DONE) && !w_full && (r_rx_cnt < r_len);
  assign bus_rd    = r_rd;
  assign bus_wr    = r_wr;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;

  assign w_tx_pop    = tx_valid && tx_ready;
  assign w_rx_push   = rx_ready && rx_valid;
  assign w_push      = w_cmpl_rd | w_rx_push;
  assign w_pop       = w_tx_pop | (w_issue && r_dir);
  assign w_push_data = r_dir ? rx_data : bus_rdata;

  // Any abnormal entry to DONE discards staged bytes.
  assign w_flush = ((r_state == S_ISSUE) && dma_abort) ||
                   (w_cmpl && (r_abort || dma_abort)) ||
                   ((r_state == S_DRAIN) && dma_abort) ||
                   w_tmo;

`ifdef DMA_MSTR_BUS_TIMEOUT_EN
  logic [7:0] r_tmo;
  logic       r_err;
  assign w_tmo   = (r_state == S_WAIT) && !w_cmpl && (r_tmo == 8'(TMO_CYC-1));
  assign dma_err = r_err;
  always_ff @(posedge bus_clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= ((r_state == S_WAIT) && !w_cmpl) ? r_tmo + 8'd1 : 8'd0;
      if ((r_state == S_IDLE) && dma_start) r_err <= 1'b0;
      else if (w_tmo)                       r_err <= 1'b1;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign dma_err = 1'b0;
`endif

  always_ff @(posedge bus_clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_dir    <= 1'b0;
      r_abort  <= 1'b0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_len    <= '0;
      r_rem    <= '0;
      r_rx_cnt <= '0;
      r_wdata  <= '0;
    end else begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      if (w_rx_push) r_rx_cnt <= r_rx_cnt + 16'd1;
      case (r_state)
        S_IDLE: if (dma_start) begin
          r_abort  <= 1'b0;
          r_dir    <= dma_dir;
          r_addr   <= dma_saddr;
          r_len    <= dma_len;
          r_rem    <= dma_len;
          r_rx_cnt <= '0;
          r_state  <= (dma_len == 16'd0) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: begin
          if (dma_abort) r_state <= S_DONE;
          else if (w_issue) begin
            r_rd <= !r_dir;
            r_wr <= r_dir;
            if (r_dir) r_wdata <= r_mem[r_rptr];
            r_state <= S_GAP;
          end
        end
        S_GAP: begin
          if (dma_abort) r_abort <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (dma_abort) r_abort <= 1'b1;
          if (w_cmpl) begin
            r_addr <= r_addr + 17'd1;
            r_rem  <= w_rem_nxt;
            if (r_abort || dma_abort)   r_state <= S_DONE;
            else if (w_rem_nxt != '0)   r_state <= S_ISSUE;
            else                        r_state <= r_dir ? S_DONE : S_DRAIN;
          end else if (w_tmo) begin
            r_state <= S_DONE;
          end
        end
        S_DRAIN: if (dma_abort || w_empty) r_state <= S_DONE;
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // Storage needs no reset; emptiness is carried by the count.
  always_ff @(posedge bus_clk) begin
    if (w_push && !w_flush) r_mem[r_wptr] <= w_push_data;
  end

endmodule
